// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario pose controller.
package mario_pkg;

    // Sprite select codes seen by the sprite mux
    localparam logic [2:0] POS_STD_BACK  = 3'b000;
    localparam logic [2:0] POS_WK_BACK   = 3'b001;
    localparam logic [2:0] POS_STD_FRONT = 3'b010;
    localparam logic [2:0] POS_WK_FRONT  = 3'b011;

    // Width of the sprite x coordinate
    localparam int unsigned X_W = 10;

    typedef enum logic {
        STAND = 1'b0,
        WALK  = 1'b1
    } state_t;

    // Sprite code from facing (1 = front) and walk phase; phase only shows while walking
    function automatic logic [2:0] pose_code(input logic facing, input logic walking,
                                             input logic phase);
        logic [2:0] code;
        unique case ({facing, walking & phase})
            2'b00:   code = POS_STD_BACK;
            2'b01:   code = POS_WK_BACK;
            2'b10:   code = POS_STD_FRONT;
            default: code = POS_WK_FRONT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous button input.
module btn_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_btn
);

    logic r_meta;
    logic r_sync;

    // Shift the raw button through two flops to settle metastability
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    assign o_btn = r_sync;

endmodule

// File: rtl/mario_pose_ctrl.sv
// Mario sprite pose and horizontal position controller (STAND/WALK FSM).
module mario_pose_ctrl
    import mario_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned STEP     = 2,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 608,
    parameter int unsigned X_INIT   = 304
) (
    input  logic           clk25,
    input  logic           rst_n,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           frame_tick,
    output logic [2:0]     pos,
    output logic [X_W-1:0] x_pos
);

    localparam int unsigned XW1 = X_W + 1;

    localparam logic [7:0]     CNT_LAST = 8'(ANIM_DIV - 1);
    localparam logic [X_W-1:0] STEP_X   = X_W'(STEP);
    localparam logic [X_W-1:0] XMIN_X   = X_W'(X_MIN);
    localparam logic [X_W-1:0] XMAX_X   = X_W'(X_MAX);
    localparam logic [X_W-1:0] XINIT_X  = X_W'(X_INIT);
    localparam logic [X_W:0]   STEP_W   = XW1'(STEP);
    localparam logic [X_W:0]   XMIN_W   = XW1'(X_MIN);
    localparam logic [X_W:0]   XMAX_W   = XW1'(X_MAX);

    logic w_left;
    logic w_right;
    logic w_dir_r;
    logic w_active;

    logic [X_W:0]   w_x_plus;
    logic [X_W-1:0] w_x_right;
    logic [X_W-1:0] w_x_left;
    logic [7:0]     w_cnt_next;
    logic           w_wrap;

    state_t         r_state;
    logic           r_facing;
    logic           r_phase;
    logic [7:0]     r_cnt;
    logic [2:0]     r_pos;
    logic [X_W-1:0] r_x;

    btn_sync u_sync_left (
        .i_clk   (clk25),
        .i_rst_n (rst_n),
        .i_btn   (btn_left),
        .o_btn   (w_left)
    );

    btn_sync u_sync_right (
        .i_clk   (clk25),
        .i_rst_n (rst_n),
        .i_btn   (btn_right),
        .o_btn   (w_right)
    );

    // Resolve direction and precompute saturated moves and animation counter
    always_comb begin
        w_dir_r    = w_right & ~w_left;
        w_active   = w_right ^ w_left;
        // Sums done one bit wider so the right-hand limit never wraps
        w_x_plus   = {1'b0, r_x} + STEP_W;
        w_x_right  = (w_x_plus > XMAX_W) ? XMAX_X : w_x_plus[X_W-1:0];
        w_x_left   = ({1'b0, r_x} < (XMIN_W + STEP_W)) ? XMIN_X : (r_x - STEP_X);
        w_wrap     = (r_cnt == CNT_LAST);
        w_cnt_next = w_wrap ? 8'd0 : (r_cnt + 8'd1);
    end

    // Pose FSM: state, facing, animation and position, all outputs registered
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= STAND;
            r_facing <= 1'b1;
            r_phase  <= 1'b0;
            r_cnt    <= 8'd0;
            r_pos    <= POS_STD_FRONT;
            r_x      <= XINIT_X;
        end else begin
            unique case (r_state)
                STAND: begin
                    if (w_active) begin
                        r_state  <= WALK;
                        r_facing <= w_dir_r;
                        r_phase  <= 1'b1;
                        r_cnt    <= 8'd0;
                        r_pos    <= pose_code(w_dir_r, 1'b1, 1'b1);
                    end
                end
                WALK: begin
                    if (!w_active) begin
                        r_state <= STAND;
                        r_phase <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_pos   <= pose_code(r_facing, 1'b0, 1'b0);
                    end else if (w_dir_r != r_facing) begin
                        // Reversal restarts the walk cycle; any tick this cycle is dropped
                        r_facing <= w_dir_r;
                        r_phase  <= 1'b1;
                        r_cnt    <= 8'd0;
                        r_pos    <= pose_code(w_dir_r, 1'b1, 1'b1);
                    end else if (frame_tick) begin
                        r_cnt   <= w_cnt_next;
                        r_phase <= r_phase ^ w_wrap;
                        r_pos   <= pose_code(r_facing, 1'b1, r_phase ^ w_wrap);
                        r_x     <= r_facing ? w_x_right : w_x_left;
                    end
                end
                default: r_state <= STAND;
            endcase
        end
    end

    assign pos   = r_pos;
    assign x_pos = r_x;

endmodule

// File: tb/tb_mario_pose_ctrl.sv
// Directed self-checking bench for mario_pose_ctrl with default parameters.
module tb_mario_pose_ctrl;

    logic       clk25;
    logic       rst_n;
    logic       btn_left;
    logic       btn_right;
    logic       frame_tick;
    logic [2:0] pos;
    logic [9:0] x_pos;

    int tests_run = 0;
    int tests_failed = 0;

    mario_pose_ctrl dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .frame_tick (frame_tick),
        .pos        (pos),
        .x_pos      (x_pos)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    // Wait n rising edges, then step 1 ns past the edge
    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk25);
        #1;
    endtask

    // One frame_tick pulse consumed by exactly one rising edge
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            edges(1);
            frame_tick = 1'b0;
            edges(1);
        end
    endtask

    task automatic do_reset();
        btn_left = 1'b0;
        btn_right = 1'b0;
        frame_tick = 1'b0;
        rst_n = 1'b0;
        edges(2);
        rst_n = 1'b1;
        edges(1);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (pos !== 3'b010) begin
            tests_failed++; $display("FAIL reset_pos got %b want 010", pos);
        end
        tests_run++;
        if (x_pos !== 10'd304) begin
            tests_failed++; $display("FAIL reset_x got %0d want 304", x_pos);
        end
        ticks(20);
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd304) begin
            tests_failed++; $display("FAIL idle_hold got pos=%b x=%0d want 010/304", pos, x_pos);
        end
    endtask

    task automatic test_walk_right();
        do_reset();
        btn_right = 1'b1;
        edges(2);
        tests_run++;
        if (pos !== 3'b010) begin
            tests_failed++; $display("FAIL latency_early got %b want 010", pos);
        end
        edges(1);
        tests_run++;
        if (pos !== 3'b011) begin
            tests_failed++; $display("FAIL latency_3rd got %b want 011", pos);
        end
        ticks(7);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd318) begin
            tests_failed++; $display("FAIL walk7 got pos=%b x=%0d want 011/318", pos, x_pos);
        end
        ticks(1);
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd320) begin
            tests_failed++; $display("FAIL walk8 got pos=%b x=%0d want 010/320", pos, x_pos);
        end
        ticks(8);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd336) begin
            tests_failed++; $display("FAIL walk16 got pos=%b x=%0d want 011/336", pos, x_pos);
        end
    endtask

    task automatic test_right_boundary();
        do_reset();
        btn_right = 1'b1;
        edges(3);
        ticks(151);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd606) begin
            tests_failed++; $display("FAIL pre_edge got pos=%b x=%0d want 011/606", pos, x_pos);
        end
        ticks(1);
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd608) begin
            tests_failed++; $display("FAIL sat_first got pos=%b x=%0d want 010/608", pos, x_pos);
        end
        ticks(4);
        tests_run++;
        if (x_pos !== 10'd608) begin
            tests_failed++; $display("FAIL sat_hold got x=%0d want 608", x_pos);
        end
        ticks(4);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd608) begin
            tests_failed++; $display("FAIL sat_anim got pos=%b x=%0d want 011/608", pos, x_pos);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        btn_right = 1'b1;
        edges(3);
        ticks(3);
        btn_right = 1'b0;
        btn_left = 1'b1;
        edges(2);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd310) begin
            tests_failed++; $display("FAIL rev_early got pos=%b x=%0d want 011/310", pos, x_pos);
        end
        edges(1);
        tests_run++;
        if (pos !== 3'b001 || x_pos !== 10'd310) begin
            tests_failed++; $display("FAIL rev_pos got pos=%b x=%0d want 001/310", pos, x_pos);
        end
        // Counter restarted from 0: no phase change until the 8th tick
        ticks(7);
        tests_run++;
        if (pos !== 3'b001 || x_pos !== 10'd296) begin
            tests_failed++; $display("FAIL rev_walk7 got pos=%b x=%0d want 001/296", pos, x_pos);
        end
        ticks(1);
        tests_run++;
        if (pos !== 3'b000 || x_pos !== 10'd294) begin
            tests_failed++; $display("FAIL rev_walk8 got pos=%b x=%0d want 000/294", pos, x_pos);
        end
    endtask

    task automatic test_both_buttons();
        do_reset();
        btn_right = 1'b1;
        edges(3);
        ticks(2);
        btn_left = 1'b1;
        edges(2);
        // Tick lands on the edge that performs WALK->STAND
        frame_tick = 1'b1;
        edges(1);
        frame_tick = 1'b0;
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd308) begin
            tests_failed++; $display("FAIL both_stop got pos=%b x=%0d want 010/308", pos, x_pos);
        end
        ticks(4);
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd308) begin
            tests_failed++; $display("FAIL both_hold got pos=%b x=%0d want 010/308", pos, x_pos);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        btn_right = 1'b1;
        edges(3);
        ticks(23);
        tests_run++;
        if (x_pos !== 10'd350) begin
            tests_failed++; $display("FAIL mid_pre got x=%0d want 350", x_pos);
        end
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd304) begin
            tests_failed++; $display("FAIL async_rst got pos=%b x=%0d want 010/304", pos, x_pos);
        end
        edges(1);
        rst_n = 1'b1;
        edges(2);
        tests_run++;
        if (pos !== 3'b010 || x_pos !== 10'd304) begin
            tests_failed++; $display("FAIL post_rst_early got pos=%b x=%0d want 010/304", pos, x_pos);
        end
        edges(1);
        tests_run++;
        if (pos !== 3'b011 || x_pos !== 10'd304) begin
            tests_failed++; $display("FAIL post_rst_walk got pos=%b x=%0d want 011/304", pos, x_pos);
        end
        ticks(1);
        tests_run++;
        if (x_pos !== 10'd306) begin
            tests_failed++; $display("FAIL post_rst_move got x=%0d want 306", x_pos);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        frame_tick = 1'b0;
        test_reset();
        test_walk_right();
        test_right_boundary();
        test_reversal();
        test_both_buttons();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
